axis_loopback_checker: RTL and testbench
========================================

Name: axis_loopback_checker

Overview:
- Parametrised AXI4-Stream traffic generator and checker for the RX FIFO datapath.
- A start pulse makes it drive a programmable burst of patterned beats out of its master port into the FIFO under test.
- It accepts the same number of beats back on its slave port and compares each against an independently generated expected pattern.
- It reports completion, a sticky error, a mismatch count and a timeout flag.
- It sits beside the FIFO in the block design and is the self-checking stimulus for simulation and on-hardware bring-up.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; legal 8..64.
- NUM_BEATS, 16, beats per transaction; legal 1..65535; the last beat carries tlast.
- PATTERN_MODE, 0, 0 = incrementing, 1 = LFSR.
- START_VALUE, 1, first data value (mode 0) or LFSR seed (mode 1); a seed of 0 is replaced by 1.
- TIMEOUT_CYCLES, 1024, consecutive RUN cycles with no accepted slave beat before timeout; 0 disables the timeout.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- init_txn  in  1  start request; acted on at its rising edge.
- m_axis_tdata  out  DATA_WIDTH  generated data.
- m_axis_tvalid  out  1  generated beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on beat NUM_BEATS-1.
- s_axis_tdata  in  DATA_WIDTH  returned data.
- s_axis_tvalid  in  1  returned beat valid.
- s_axis_tready  out  1  checker ready.
- s_axis_tlast  in  1  returned last marker.
- busy  out  1  high in RUN.
- done  out  1  transaction complete; sticky until the next start.
- error  out  1  sticky: any mismatch or timeout.
- err_count  out  16  mismatching beats, saturating at 16'hFFFF.
- timeout  out  1  sticky: the watchdog expired.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-high.
  - While rst=1 all outputs are 0, the state is IDLE, both beat counters are 0, and both pattern generators reload their start value.
  - Reset asserted mid-RUN aborts immediately; no partial done or error survives.
- Start detection:
  - init_txn is registered; start = init_txn & ~init_txn_q.
  - A start in IDLE or DONE clears done, error, err_count, timeout and the counters, reloads the generators, and enters RUN on the next cycle.
  - A start during RUN is ignored.
- State machine (IDLE -> RUN -> DONE -> RUN on the next start):
  - RUN -> DONE when tx_cnt==NUM_BEATS and rx_cnt==NUM_BEATS, or when the watchdog expires.
  - busy=1 only in RUN; done=1 in DONE.
- Generator:
  - m_axis_tvalid=1 in RUN while tx_cnt<NUM_BEATS.
  - A beat transfers when tvalid & tready; tx_cnt then increments and the generator advances.
  - tdata and tlast hold stable while tvalid=1 and tready=0.
  - Mode 0: beat i = (START_VALUE + i) mod 2^DATA_WIDTH.
  - Mode 1: 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, shifting once per accepted beat. Beat data is the LFSR state replicated to 64 bits and truncated to DATA_WIDTH; beat 0 is the seed.
- Checker:
  - s_axis_tready=1 in RUN while rx_cnt<NUM_BEATS, otherwise 0. Beats offered outside RUN, or after NUM_BEATS, are not accepted.
  - It keeps its own expected-pattern generator, identical to the transmit one, advancing per accepted slave beat.
  - A beat mismatches if tdata differs from expected, or tlast != (rx_cnt==NUM_BEATS-1).
  - A mismatch sets error and increments err_count (saturating). The checker's expected pattern still advances; it does not resynchronise.
- Latency: none required between the ports. The checker must accept a returned beat in the same cycle the generator issues, so transmit and receive overlap; a zero-latency loopback completes in NUM_BEATS cycles of RUN.
- Watchdog:
  - Counts RUN cycles with no accepted slave beat; it clears on each accepted beat.
  - When it reaches TIMEOUT_CYCLES: timeout=1, error=1, go to DONE; err_count is unchanged.
- Simultaneous events: the final transmit and final receive may land in the same cycle, and DONE is entered on the following cycle. A watchdog expiry in the same cycle as the final receive beat is not a timeout.

Test Plan:
- Direct loopback (m to s, tready always 1), mode 0, START_VALUE=1, NUM_BEATS=16, DATA_WIDTH=32 -> data 1..16; tlast on the 16th beat; done=1 exactly 17 cycles after RUN entry; error=0; err_count=0.
- Through the RX FIFO with random m_axis_tready backpressure and s_axis_tvalid gaps, mode 1, seed 0 -> seed treated as 1; m_axis_tdata stable during stalls; done=1; error=0.
- Corrupt bit 0 of returned beats 3 and 7, plus drop tlast on the final beat -> err_count=3, error=1, done=1, timeout=0.
- Loop that returns only 10 of 16 beats, TIMEOUT_CYCLES=64 -> timeout=1, error=1, done=1 64 cycles after the 10th accepted beat; rx_cnt=10.
- Second init_txn pulse during RUN is ignored; a pulse after done -> flags clear and a second identical transaction passes. init_txn held high for 20 cycles -> exactly one transaction.
- Assert rst for 1 cycle mid-transaction -> all outputs 0 next cycle; a subsequent start runs a clean pass; DATA_WIDTH=8 in mode 0 with START_VALUE=250 and NUM_BEATS=10 -> data wraps 250..255, 0..3.

Source files
------------

// File: rtl/axis_loopback_checker.sv
// AXI4-Stream loopback traffic generator and checker.
// A start pulse sends NUM_BEATS patterned beats out of the master port and
// checks the same number of beats returned on the slave port against an
// independent copy of the pattern. Reports done, sticky error, a saturating
// mismatch count and a watchdog timeout.
//
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are
// both 1. The master holds tdata/tlast stable while tvalid=1 and tready=0.
// Neither side's valid/ready depends combinationally on the other side.
module axis_loopback_checker #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_BEATS      = 16,
  parameter int unsigned PATTERN_MODE   = 0,
  parameter logic [63:0] START_VALUE    = 64'd1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_txn,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           err_count,
  output logic                  timeout
);

  localparam logic [15:0] NB       = 16'(NUM_BEATS);
  localparam logic [15:0] LAST_IDX = 16'(NUM_BEATS - 1);
  localparam logic [31:0] TO       = 32'(TIMEOUT_CYCLES);

  // Generator state is 64 bits wide: mode 0 keeps a plain counter whose low
  // DATA_WIDTH bits are the beat; mode 1 keeps the 32-bit LFSR in the low
  // half (upper half stays zero). An all-zero LFSR seed would lock up.
  localparam logic [63:0] SEED = (PATTERN_MODE == 1) ?
    ((START_VALUE[31:0] == 32'd0) ? 64'd1 : {32'd0, START_VALUE[31:0]}) :
    START_VALUE;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  function automatic logic [63:0] gen_next(input logic [63:0] s);
    logic [63:0] r;
    if (PATTERN_MODE == 1) begin
      // Fibonacci LFSR, taps 32,22,2,1 (x^32+x^22+x^2+x+1)
      r = {s[63:32], s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    end else begin
      r = s + 64'd1;
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] gen_data(input logic [63:0] s);
    logic [63:0] r;
    if (PATTERN_MODE == 1) r = {s[31:0], s[31:0]};
    else                   r = s;
    return r[DATA_WIDTH-1:0];
  endfunction

  state_t       state_q;
  logic         init_q;
  logic [15:0]  tx_cnt_q;
  logic [15:0]  rx_cnt_q;
  logic [63:0]  tx_gen_q;
  logic [63:0]  rx_gen_q;
  logic [31:0]  wd_q;
  logic         error_q;
  logic         timeout_q;
  logic [15:0]  err_cnt_q;

  logic                  start;
  logic                  m_fire;
  logic                  s_fire;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  exp_last;
  logic                  beat_bad;
  logic                  wd_expire;
  logic                  all_done;

  // Start detection, handshakes, beat comparison and watchdog expiry
  always_comb begin
    start     = init_txn & ~init_q;
    m_fire    = m_axis_tvalid & m_axis_tready;
    s_fire    = s_axis_tvalid & s_axis_tready;
    exp_data  = gen_data(rx_gen_q);
    exp_last  = (rx_cnt_q == LAST_IDX);
    beat_bad  = (s_axis_tdata != exp_data) || (s_axis_tlast != exp_last);
    // An accepted beat in the same cycle always wins over expiry
    wd_expire = (TO != 32'd0) && !s_fire && ((wd_q + 32'd1) == TO);
    all_done  = (tx_cnt_q == NB) && (rx_cnt_q == NB);
  end

  // Port outputs decoded from registered state
  always_comb begin
    busy          = (state_q == ST_RUN);
    done          = (state_q == ST_DONE);
    m_axis_tvalid = busy && (tx_cnt_q < NB);
    s_axis_tready = busy && (rx_cnt_q < NB);
    m_axis_tdata  = m_axis_tvalid ? gen_data(tx_gen_q) : '0;
    m_axis_tlast  = m_axis_tvalid && (tx_cnt_q == LAST_IDX);
    error         = error_q;
    timeout       = timeout_q;
    err_count     = err_cnt_q;
  end

  // Control FSM with beat counters, pattern generators and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      init_q    <= 1'b0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_gen_q  <= SEED;
      rx_gen_q  <= SEED;
      wd_q      <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      init_q <= init_txn;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            tx_gen_q  <= SEED;
            rx_gen_q  <= SEED;
            wd_q      <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            err_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (m_fire) begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
            tx_gen_q <= gen_next(tx_gen_q);
          end
          if (s_fire) begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
            rx_gen_q <= gen_next(rx_gen_q);
            wd_q     <= '0;
            if (beat_bad) begin
              error_q <= 1'b1;
              if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
          end else if (TO != 32'd0) begin
            wd_q <= wd_q + 32'd1;
          end
          if (all_done) begin
            state_q <= ST_DONE;
          end else if (wd_expire) begin
            timeout_q <= 1'b1;
            error_q   <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_loopback_checker.sv
// Directed bench for axis_loopback_checker: three instances cover
// incrementing 32-bit, LFSR through a modelled FIFO, and 8-bit wrap.
module tb_axis_loopback_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // ---------------- u0: mode 0, 32-bit, 16 beats, timeout 64 ----------------
  logic        u0_init = 1'b0;
  logic [31:0] u0_m_tdata, u0_s_tdata;
  logic        u0_m_tvalid, u0_m_tlast, u0_s_tready;
  logic        u0_m_tready = 1'b1;
  logic        u0_s_tvalid, u0_s_tlast;
  logic        u0_busy, u0_done, u0_error, u0_timeout;
  logic [15:0] u0_err_count;
  logic [1:0]  u0_mode = 2'd0;   // 0 direct, 1 corrupt, 2 return only 10
  int          u0_idx = 0;
  int          u0_tx_total = 0;

  axis_loopback_checker #(
    .DATA_WIDTH(32), .NUM_BEATS(16), .PATTERN_MODE(0),
    .START_VALUE(64'd1), .TIMEOUT_CYCLES(64)
  ) u0 (
    .clk(clk), .rst(rst), .init_txn(u0_init),
    .m_axis_tdata(u0_m_tdata), .m_axis_tvalid(u0_m_tvalid),
    .m_axis_tready(u0_m_tready), .m_axis_tlast(u0_m_tlast),
    .s_axis_tdata(u0_s_tdata), .s_axis_tvalid(u0_s_tvalid),
    .s_axis_tready(u0_s_tready), .s_axis_tlast(u0_s_tlast),
    .busy(u0_busy), .done(u0_done), .error(u0_error),
    .err_count(u0_err_count), .timeout(u0_timeout)
  );

  always_comb begin
    u0_s_tdata  = u0_m_tdata;
    u0_s_tlast  = u0_m_tlast;
    u0_s_tvalid = u0_m_tvalid;
    if (u0_mode == 2'd1) begin
      if (u0_idx == 3 || u0_idx == 7) u0_s_tdata[0] = ~u0_m_tdata[0];
      if (u0_idx == 15) u0_s_tlast = 1'b0;
    end
    if (u0_mode == 2'd2 && u0_idx >= 10) u0_s_tvalid = 1'b0;
  end

  always @(posedge clk) begin
    if (!u0_busy) u0_idx <= 0;
    else if (u0_m_tvalid && u0_m_tready) u0_idx <= u0_idx + 1;
    if (u0_m_tvalid && u0_m_tready) u0_tx_total <= u0_tx_total + 1;
  end

  // ---------------- u1: LFSR, seed 0, through a FIFO model ----------------
  logic        u1_init = 1'b0;
  logic [31:0] u1_m_tdata;
  logic [31:0] u1_s_tdata = '0;
  logic        u1_m_tvalid, u1_m_tlast, u1_s_tready;
  logic        u1_m_tready = 1'b0;
  logic        u1_s_tvalid = 1'b0;
  logic        u1_s_tlast = 1'b0;
  logic        u1_busy, u1_done, u1_error, u1_timeout;
  logic [15:0] u1_err_count;

  axis_loopback_checker #(
    .DATA_WIDTH(32), .NUM_BEATS(16), .PATTERN_MODE(1),
    .START_VALUE(64'd0), .TIMEOUT_CYCLES(1024)
  ) u1 (
    .clk(clk), .rst(rst), .init_txn(u1_init),
    .m_axis_tdata(u1_m_tdata), .m_axis_tvalid(u1_m_tvalid),
    .m_axis_tready(u1_m_tready), .m_axis_tlast(u1_m_tlast),
    .s_axis_tdata(u1_s_tdata), .s_axis_tvalid(u1_s_tvalid),
    .s_axis_tready(u1_s_tready), .s_axis_tlast(u1_s_tlast),
    .busy(u1_busy), .done(u1_done), .error(u1_error),
    .err_count(u1_err_count), .timeout(u1_timeout)
  );

  // ---------------- u2: mode 0, 8-bit, 10 beats from 250 ----------------
  logic       u2_init = 1'b0;
  logic [7:0] u2_m_tdata;
  logic       u2_m_tvalid, u2_m_tlast, u2_s_tready;
  logic       u2_busy, u2_done, u2_error, u2_timeout;
  logic [15:0] u2_err_count;
  logic       u2_m_tready = 1'b1;

  axis_loopback_checker #(
    .DATA_WIDTH(8), .NUM_BEATS(10), .PATTERN_MODE(0),
    .START_VALUE(64'd250), .TIMEOUT_CYCLES(1024)
  ) u2 (
    .clk(clk), .rst(rst), .init_txn(u2_init),
    .m_axis_tdata(u2_m_tdata), .m_axis_tvalid(u2_m_tvalid),
    .m_axis_tready(u2_m_tready), .m_axis_tlast(u2_m_tlast),
    .s_axis_tdata(u2_m_tdata), .s_axis_tvalid(u2_m_tvalid),
    .s_axis_tready(u2_s_tready), .s_axis_tlast(u2_m_tlast),
    .busy(u2_busy), .done(u2_done), .error(u2_error),
    .err_count(u2_err_count), .timeout(u2_timeout)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Pulse u0 start; returns between the RUN-entry edge and the next edge
  task automatic u0_start(input string tag);
    @(negedge clk) u0_init = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy"}, 64'(u0_busy), 64'd1);
    chk({tag, "_cleared"}, {u0_done, u0_error, u0_timeout, u0_err_count}, 64'd0);
    @(negedge clk) u0_init = 1'b0;
  endtask

  // Expects done to rise exactly 17 edges after RUN entry
  task automatic u0_expect_done17(input string tag);
    repeat (16) @(posedge clk);
    #1 chk({tag, "_done_early"}, 64'(u0_done), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done"}, 64'(u0_done), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [32:0] fifo[$];
    logic [31:0] lf;
    logic [31:0] held;
    logic [31:0] b0, b1;
    logic        stall_prev, m_fire, s_fire;
    int          k, tx_before;
    logic [7:0]  exp8[10];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {u0_busy, u0_done, u0_error, u0_timeout, u0_m_tvalid,
                        u0_s_tready, u0_m_tlast, u0_err_count}, 64'd0);
    chk("rst_tdata", 64'(u0_m_tdata), 64'd0);
    chk("rst_u1_flags", {u1_busy, u1_done, u1_m_tvalid, u1_s_tready}, 64'd0);
    @(negedge clk) rst = 1'b0;

    // Direct loopback, data 1..16, tlast on 16th beat, done at 17
    u0_mode = 2'd0;
    tx_before = u0_tx_total;
    u0_start("t1");
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1_data%0d", i), 64'(u0_m_tdata), 64'(i + 1));
      chk($sformatf("t1_last%0d", i), 64'(u0_m_tlast), 64'(i == 15));
      @(negedge clk);
    end
    chk("t1_done_early", 64'(u0_done), 64'd0);
    @(posedge clk); #1;
    chk("t1_done", 64'(u0_done), 64'd1);
    chk("t1_flags", {u0_busy, u0_error, u0_timeout, u0_err_count}, 64'd0);
    chk("t1_beats", 64'(u0_tx_total - tx_before), 64'd16);

    // LFSR through FIFO with backpressure and valid gaps
    @(negedge clk) u1_init = 1'b1;
    @(posedge clk); #1;
    chk("t2_busy", 64'(u1_busy), 64'd1);
    @(negedge clk) u1_init = 1'b0;
    lf = 32'd1; k = 0; stall_prev = 1'b0; held = '0; b0 = '0; b1 = '0;
    for (int g = 0; g < 2000 && !u1_done; g++) begin
      @(negedge clk);
      if (stall_prev && u1_m_tvalid) chk("t2_stall_stable", 64'(u1_m_tdata), 64'(held));
      u1_m_tready = ($urandom_range(0, 3) != 0);
      u1_s_tvalid = (fifo.size() > 0) && ($urandom_range(0, 2) != 0);
      if (fifo.size() > 0) {u1_s_tlast, u1_s_tdata} = fifo[0];
      else {u1_s_tlast, u1_s_tdata} = '0;
      #1;
      m_fire = u1_m_tvalid && u1_m_tready;
      s_fire = u1_s_tvalid && u1_s_tready;
      stall_prev = u1_m_tvalid && !u1_m_tready;
      held = u1_m_tdata;
      if (m_fire) begin
        chk($sformatf("t2_data%0d", k), 64'(u1_m_tdata), 64'(lf));
        chk($sformatf("t2_last%0d", k), 64'(u1_m_tlast), 64'(k == 15));
        if (k == 0) b0 = u1_m_tdata;
        if (k == 1) b1 = u1_m_tdata;
        lf = lfsr_next(lf);
        k++;
      end
      @(posedge clk);
      if (s_fire) void'(fifo.pop_front());
      if (m_fire) fifo.push_back({u1_m_tlast, u1_m_tdata});
      #1;
    end
    u1_s_tvalid = 1'b0;
    chk("t2_seed_beat0", 64'(b0), 64'd1);
    chk("t2_seed_beat1", 64'(b1), 64'd3);
    chk("t2_beats", 64'(k), 64'd16);
    chk("t2_done", 64'(u1_done), 64'd1);
    chk("t2_flags", {u1_error, u1_timeout, u1_err_count}, 64'd0);

    // Corrupt beats 3 and 7 bit 0, drop tlast on final beat
    u0_mode = 2'd1;
    u0_start("t3");
    u0_expect_done17("t3");
    chk("t3_err_count", 64'(u0_err_count), 64'd3);
    chk("t3_error", 64'(u0_error), 64'd1);
    chk("t3_timeout", 64'(u0_timeout), 64'd0);

    // Only 10 beats returned: timeout 64 cycles after the 10th
    u0_mode = 2'd2;
    tx_before = u0_tx_total;
    u0_start("t4");
    repeat (73) @(posedge clk);
    #1 chk("t4_done_early", 64'(u0_done), 64'd0);
    @(posedge clk); #1;
    chk("t4_done", 64'(u0_done), 64'd1);
    chk("t4_timeout", 64'(u0_timeout), 64'd1);
    chk("t4_error", 64'(u0_error), 64'd1);
    chk("t4_err_count", 64'(u0_err_count), 64'd0);
    chk("t4_rx_cnt", 64'(u0.rx_cnt_q), 64'd10);
    chk("t4_tx_beats", 64'(u0_tx_total - tx_before), 64'd16);

    // Second pulse during RUN is ignored
    u0_mode = 2'd0;
    tx_before = u0_tx_total;
    u0_start("t5a");
    @(negedge clk);
    @(negedge clk) u0_init = 1'b1;
    @(negedge clk) u0_init = 1'b0;
    repeat (13) @(posedge clk);
    #1 chk("t5a_done_early", 64'(u0_done), 64'd0);
    @(posedge clk); #1;
    chk("t5a_done", 64'(u0_done), 64'd1);
    chk("t5a_beats", 64'(u0_tx_total - tx_before), 64'd16);
    chk("t5a_flags", {u0_error, u0_timeout, u0_err_count}, 64'd0);

    // Pulse after done: identical clean transaction
    u0_start("t5b");
    u0_expect_done17("t5b");
    chk("t5b_flags", {u0_error, u0_timeout, u0_err_count}, 64'd0);

    // init held high 20 cycles: exactly one transaction
    tx_before = u0_tx_total;
    @(negedge clk) u0_init = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t5c_done", {u0_done, u0_busy}, 64'b10);
    @(negedge clk) u0_init = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5c_still_done", {u0_done, u0_busy}, 64'b10);
    chk("t5c_beats", 64'(u0_tx_total - tx_before), 64'd16);

    // Reset mid-transaction, then a clean pass
    u0_start("t6");
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_outputs", {u0_busy, u0_done, u0_error, u0_timeout, u0_m_tvalid,
                           u0_s_tready, u0_m_tlast, u0_err_count}, 64'd0);
    chk("t6_rst_tdata", 64'(u0_m_tdata), 64'd0);
    @(negedge clk) rst = 1'b0;
    u0_start("t6b");
    chk("t6b_first_data", 64'(u0_m_tdata), 64'd1);
    u0_expect_done17("t6b");
    chk("t6b_flags", {u0_error, u0_timeout, u0_err_count}, 64'd0);

    // 8-bit wrap: 250..255, 0..3
    exp8 = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2, 8'd3};
    @(negedge clk) u2_init = 1'b1;
    @(posedge clk); #1;
    chk("t7_busy", 64'(u2_busy), 64'd1);
    @(negedge clk) u2_init = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t7_data%0d", i), 64'(u2_m_tdata), 64'(exp8[i]));
      chk($sformatf("t7_last%0d", i), 64'(u2_m_tlast), 64'(i == 9));
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("t7_done", 64'(u2_done), 64'd1);
    chk("t7_flags", {u2_error, u2_timeout, u2_err_count}, 64'd0);

    // Final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
